// File: rtl/rect_overlay_scheduler.sv
// Per-frame scheduler: snapshots the detector rectangle list on frame start and
// issues the non-empty, non-degenerate slots to the text renderer in ascending y1 order.
module rect_overlay_scheduler #(
   parameter int         RECT_N      = 8,
   parameter int         IDX_W       = 3,
   parameter logic [3:0] EMPTY_LABEL = 4'hF
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  i_frame_start,
   input  logic [RECT_N*4-1:0]   i_label,
   input  logic [RECT_N*32-1:0]  i_item,
   output logic                  o_desc_valid,
   input  logic                  i_desc_ready,
   output logic [IDX_W-1:0]      o_desc_idx,
   output logic [3:0]            o_desc_label,
   output logic [31:0]           o_desc_item,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic [IDX_W:0]        o_desc_cnt
);

   typedef enum logic [1:0] {IDLE, SEL, ISSUE, DONE} state_t;

   state_t               state, state_nxt;
   logic [RECT_N*4-1:0]  shadow_label;
   logic [RECT_N*32-1:0] shadow_item;
   logic [RECT_N-1:0]    issued;
   logic [RECT_N-1:0]    eligible;
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [7:0]           pick_y1;
   logic [3:0]           pick_label;
   logic [31:0]          pick_item;
   logic                 xfer;

   function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] c);
      if (c >= (IDX_W+1)'(RECT_N))
         return (IDX_W+1)'(RECT_N);
      else
         return c + (IDX_W+1)'(1);
   endfunction

   assign xfer         = o_desc_valid & i_desc_ready;
   assign o_busy       = (state != IDLE);
   assign o_frame_done = (state == DONE);

   // Item layout is {x1,y1,x2,y2}; an entry needs a real label and positive extent.
   always_comb begin
      eligible = '0;
      for (int k = 0; k < RECT_N; k++) begin
         eligible[k] = (shadow_label[4*k +: 4] != EMPTY_LABEL)
                    && (shadow_item[32*k+8 +: 8] > shadow_item[32*k+24 +: 8])
                    && (shadow_item[32*k +: 8] > shadow_item[32*k+16 +: 8])
                    && !issued[k];
      end
   end

   // Strict less-than keeps the lowest index on equal y1.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_y1    = '0;
      pick_label = '0;
      pick_item  = '0;
      for (int k = 0; k < RECT_N; k++) begin
         if (eligible[k] && (!pick_found || (shadow_item[32*k+16 +: 8] < pick_y1))) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(k);
            pick_y1    = shadow_item[32*k+16 +: 8];
            pick_label = shadow_label[4*k +: 4];
            pick_item  = shadow_item[32*k +: 32];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         SEL:     state_nxt = pick_found ? ISSUE : DONE;
         ISSUE:   if (xfer) state_nxt = SEL;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (i_frame_start)
         state_nxt = SEL;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Selection stage -> issue stage: descriptor registers held until the transfer.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         shadow_label <= '0;
         shadow_item  <= '0;
         issued       <= '0;
         o_desc_valid <= 1'b0;
         o_desc_idx   <= '0;
         o_desc_label <= '0;
         o_desc_item  <= '0;
         o_desc_cnt   <= '0;
      end else if (i_frame_start) begin
         shadow_label <= i_label;
         shadow_item  <= i_item;
         issued       <= '0;
         o_desc_valid <= 1'b0;
         o_desc_cnt   <= '0;
      end else begin
         if (state == SEL && pick_found) begin
            o_desc_idx   <= pick_idx;
            o_desc_label <= pick_label;
            o_desc_item  <= pick_item;
            o_desc_valid <= 1'b1;
         end
         if (state == ISSUE && xfer) begin
            issued[o_desc_idx] <= 1'b1;
            o_desc_cnt         <= sat_inc(o_desc_cnt);
            o_desc_valid       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rect_overlay_scheduler.sv
// Directed bench for rect_overlay_scheduler; descriptors expected per frame are queued
// as each frame is set up and checked against every handshake transfer.
module tb_rect_overlay_scheduler;

   localparam int RECT_N = 8;
   localparam int IDX_W  = 3;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [3:0]       label;
      logic [31:0]      item;
   } desc_t;

   logic                 sys_clk = 1'b0;
   logic                 sys_rst_n = 1'b0;
   logic                 i_frame_start = 1'b0;
   logic                 i_desc_ready = 1'b0;
   logic [RECT_N*4-1:0]  i_label = '1;
   logic [RECT_N*32-1:0] i_item = '0;
   logic                 o_desc_valid;
   logic [IDX_W-1:0]     o_desc_idx;
   logic [3:0]           o_desc_label;
   logic [31:0]          o_desc_item;
   logic                 o_busy;
   logic                 o_frame_done;
   logic [IDX_W:0]       o_desc_cnt;

   int    checks = 0;
   int    failures = 0;
   desc_t sb[$];

   always #5 sys_clk = ~sys_clk;

   rect_overlay_scheduler #(.RECT_N(RECT_N), .IDX_W(IDX_W), .EMPTY_LABEL(4'hF)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_frame_start(i_frame_start),
      .i_label(i_label), .i_item(i_item), .o_desc_valid(o_desc_valid),
      .i_desc_ready(i_desc_ready), .o_desc_idx(o_desc_idx), .o_desc_label(o_desc_label),
      .o_desc_item(o_desc_item), .o_busy(o_busy), .o_frame_done(o_frame_done),
      .o_desc_cnt(o_desc_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] x1, input logic [7:0] y1,
                                      input logic [7:0] x2, input logic [7:0] y2);
      return {x1, y1, x2, y2};
   endfunction

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_slots();
      i_label = '1;
      i_item  = '0;
   endtask

   task automatic set_slot(input int k, input logic [3:0] l, input logic [31:0] it);
      i_label[4*k +: 4]  = l;
      i_item[32*k +: 32] = it;
   endtask

   task automatic push(input int k, input logic [3:0] l, input logic [31:0] it);
      desc_t d;
      d.idx   = IDX_W'(k);
      d.label = l;
      d.item  = it;
      sb.push_back(d);
   endtask

   // Pulse frame start so it is sampled by the next edge; returns just after that edge.
   task automatic start_frame();
      i_frame_start = 1'b1;
      cyc();
      i_frame_start = 1'b0;
   endtask

   // Inputs are stable at the falling edge, so a transfer seen here completes at the next rise.
   always @(negedge sys_clk) begin
      desc_t e;
      if (sys_rst_n && o_desc_valid && i_desc_ready && !i_frame_start) begin
         check("xfer_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("xfer_idx", 64'(o_desc_idx), 64'(e.idx));
            check("xfer_label", 64'(o_desc_label), 64'(e.label));
            check("xfer_item", 64'(o_desc_item), 64'(e.item));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      // Reset held three cycles
      sys_rst_n = 1'b0;
      repeat (3) cyc();
      check("rst_valid", 64'(o_desc_valid), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_frame_done), 64'd0);
      check("rst_cnt", 64'(o_desc_cnt), 64'd0);
      sys_rst_n = 1'b1;
      cyc();
      check("idle_busy", 64'(o_busy), 64'd0);
      check("idle_done", 64'(o_frame_done), 64'd0);
      check("idle_outs", {o_desc_idx, o_desc_label, o_desc_item}, 64'd0);

      // Three valid slots, y1 order 10,40,40 -> idx 2,1,5
      clear_slots();
      set_slot(1, 4'h1, mk(8'd10, 8'd40, 8'd50, 8'd60));
      set_slot(2, 4'h2, mk(8'd5, 8'd10, 8'd30, 8'd20));
      set_slot(5, 4'h5, mk(8'd0, 8'd40, 8'd8, 8'd45));
      push(2, 4'h2, mk(8'd5, 8'd10, 8'd30, 8'd20));
      push(1, 4'h1, mk(8'd10, 8'd40, 8'd50, 8'd60));
      push(5, 4'h5, mk(8'd0, 8'd40, 8'd8, 8'd45));
      i_desc_ready = 1'b1;
      start_frame();
      check("t2_sel_busy", 64'(o_busy), 64'd1);
      check("t2_sel_valid", 64'(o_desc_valid), 64'd0);
      cyc();
      check("t2_first_valid", 64'(o_desc_valid), 64'd1);
      check("t2_first_idx", 64'(o_desc_idx), 64'd2);
      cyc();
      check("t2_bubble1", 64'(o_desc_valid), 64'd0);
      cyc();
      check("t2_second_idx", {63'd0, o_desc_valid} << 8 | 64'(o_desc_idx), 64'h101);
      cyc();
      check("t2_bubble2", 64'(o_desc_valid), 64'd0);
      cyc();
      check("t2_third_idx", {63'd0, o_desc_valid} << 8 | 64'(o_desc_idx), 64'h105);
      cyc();
      check("t2_cnt", 64'(o_desc_cnt), 64'd3);
      check("t2_no_done_yet", 64'(o_frame_done), 64'd0);
      cyc();
      check("t2_done", 64'(o_frame_done), 64'd1);
      cyc();
      check("t2_done_pulse", 64'(o_frame_done), 64'd0);
      check("t2_idle_busy", 64'(o_busy), 64'd0);
      check("t2_cnt_held", 64'(o_desc_cnt), 64'd3);
      check("t2_sb_empty", 64'(sb.size()), 64'd0);

      // Backpressure: held stable five cycles, then a single transfer
      clear_slots();
      set_slot(3, 4'h7, mk(8'd1, 8'd2, 8'd3, 8'd4));
      i_desc_ready = 1'b0;
      start_frame();
      cyc();
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", 64'(o_desc_valid), 64'd1);
         check("t3_hold_desc", {o_desc_idx, o_desc_label, o_desc_item},
               {3'd3, 4'h7, mk(8'd1, 8'd2, 8'd3, 8'd4)});
         cyc();
      end
      push(3, 4'h7, mk(8'd1, 8'd2, 8'd3, 8'd4));
      i_desc_ready = 1'b1;
      cyc();
      check("t3_valid_drop", 64'(o_desc_valid), 64'd0);
      check("t3_cnt", 64'(o_desc_cnt), 64'd1);
      cyc();
      check("t3_done", 64'(o_frame_done), 64'd1);
      cyc();
      check("t3_idle", 64'(o_busy), 64'd0);
      i_desc_ready = 1'b0;

      // Nothing eligible: empty labels, zero width, inverted and zero height
      clear_slots();
      set_slot(0, 4'h1, mk(8'd20, 8'd5, 8'd20, 8'd30));
      set_slot(4, 4'h2, mk(8'd1, 8'd50, 8'd9, 8'd40));
      set_slot(6, 4'h3, mk(8'd1, 8'd30, 8'd9, 8'd30));
      i_desc_ready = 1'b1;
      start_frame();
      check("t4_sel_done", 64'(o_frame_done), 64'd0);
      check("t4_cnt_cleared", 64'(o_desc_cnt), 64'd0);
      cyc();
      check("t4_done", 64'(o_frame_done), 64'd1);
      check("t4_no_valid", 64'(o_desc_valid), 64'd0);
      cyc();
      check("t4_done_pulse", 64'(o_frame_done), 64'd0);
      check("t4_cnt", 64'(o_desc_cnt), 64'd0);

      // Restart while a descriptor is pending
      clear_slots();
      set_slot(0, 4'h1, mk(8'd0, 8'd30, 8'd10, 8'd40));
      set_slot(6, 4'h6, mk(8'd0, 8'd20, 8'd10, 8'd25));
      push(6, 4'h6, mk(8'd0, 8'd20, 8'd10, 8'd25));
      i_desc_ready = 1'b1;
      start_frame();
      cyc();
      check("t5_first_idx", 64'(o_desc_idx), 64'd6);
      cyc();
      i_desc_ready = 1'b0;
      check("t5_cnt_one", 64'(o_desc_cnt), 64'd1);
      cyc();
      check("t5_pending", {63'd0, o_desc_valid} << 8 | 64'(o_desc_idx), 64'h100);
      clear_slots();
      set_slot(3, 4'h9, mk(8'd2, 8'd50, 8'd9, 8'd60));
      set_slot(7, 4'h4, mk(8'd3, 8'd15, 8'd8, 8'd16));
      set_slot(1, 4'h2, mk(8'd0, 8'd15, 8'd5, 8'd20));
      start_frame();
      check("t5_restart_valid", 64'(o_desc_valid), 64'd0);
      check("t5_restart_cnt", 64'(o_desc_cnt), 64'd0);
      check("t5_restart_busy", 64'(o_busy), 64'd1);
      push(1, 4'h2, mk(8'd0, 8'd15, 8'd5, 8'd20));
      push(7, 4'h4, mk(8'd3, 8'd15, 8'd8, 8'd16));
      push(3, 4'h9, mk(8'd2, 8'd50, 8'd9, 8'd60));
      i_desc_ready = 1'b1;
      set_slot(1, 4'hF, 32'd0);
      cyc();
      check("t5_new_first", {63'd0, o_desc_valid} << 8 | 64'(o_desc_idx), 64'h101);
      n = 0;
      while (!o_frame_done && n < 20) begin
         cyc();
         n++;
      end
      check("t5_done_seen", 64'(o_frame_done), 64'd1);
      check("t5_cnt", 64'(o_desc_cnt), 64'd3);
      check("t5_sb_empty", 64'(sb.size()), 64'd0);
      cyc();

      // Reset during ISSUE
      clear_slots();
      set_slot(2, 4'h3, mk(8'd0, 8'd5, 8'd10, 8'd9));
      set_slot(4, 4'h8, mk(8'd0, 8'd7, 8'd10, 8'd9));
      push(2, 4'h3, mk(8'd0, 8'd5, 8'd10, 8'd9));
      i_desc_ready = 1'b1;
      start_frame();
      cyc();
      check("t6_first_idx", 64'(o_desc_idx), 64'd2);
      cyc();
      i_desc_ready = 1'b0;
      cyc();
      check("t6_pending", {o_desc_valid, o_desc_cnt}, {1'b1, 4'd1});
      sys_rst_n = 1'b0;
      cyc();
      check("t6_rst_valid", 64'(o_desc_valid), 64'd0);
      check("t6_rst_busy", 64'(o_busy), 64'd0);
      check("t6_rst_cnt", 64'(o_desc_cnt), 64'd0);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         i_desc_ready = i[0];
         cyc();
         check("t6_post_valid", 64'(o_desc_valid), 64'd0);
         check("t6_post_cnt", 64'(o_desc_cnt), 64'd0);
         check("t6_post_busy", 64'(o_busy), 64'd0);
      end
      check("t6_sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
